rr_lock_arbiter: RTL and testbench

Parametrised round-robin arbiter with registered grants, an internally maintained rotating priority pointer, and an optional grant lock. The lock holds a grant for a full multi-cycle packet until the winner releases it. It serves as the per-output-port arbiter in the router switch allocator. It supersedes the externally-pointered, unregistered arbiter: pointer management, one-hot grant and packet locking are now inside the block.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_lock_arbiter_if.sv | 42 ++++
 rtl/rr_pick.sv | 53 +++++
 rtl/rr_lock_arbiter.sv | 85 ++++++++
 tb/tb_rr_lock_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin lock arbiter.
//   arb_state_t   : arbiter FSM state (IDLE / LOCKED)
//   ARB_PTR_W_MIN : smallest legal pointer / index width
//   wrap_inc      : modulo-n increment done with compare-and-subtract, so
//                   non-power-of-two port counts wrap correctly
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int ARB_PTR_W_MIN = 1;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter_if
// Request/grant bundle between requesters and one round-robin lock arbiter.
//   request     : per-port request level                (requester -> arbiter)
//   pkt_release : per-port end-of-packet strobe         (requester -> arbiter)
//                 ("release" is a reserved SystemVerilog keyword)
//   grant       : registered one-hot grant or all-zero  (arbiter -> requester)
//   chosen      : registered index of the granted port  (arbiter -> requester)
//   given       : registered, 1 when any grant bit set  (arbiter -> requester)
//   state_dbg   : current FSM state, for observation only
//   ptr_dbg     : current rotating priority pointer, for observation only
// Handshake: a port holds request high for as long as it wants the resource;
// it owns the resource in every cycle where grant[port] is 1, and ends its
// tenure either by pulsing pkt_release[port] in its last granted cycle or by
// dropping request[port]. Strobes on ports that do not hold the grant are
// ignored.
// -----------------------------------------------------------------------------
interface rr_lock_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = $clog2(NUM_PORTS)
);
    import arb_pkg::*;

    logic [NUM_PORTS-1:0] request;
    logic [NUM_PORTS-1:0] pkt_release;
    logic [NUM_PORTS-1:0] grant;
    logic [PTR_W-1:0]     chosen;
    logic                 given;
    arb_state_t           state_dbg;
    logic [PTR_W-1:0]     ptr_dbg;

    modport master (
        output request, pkt_release,
        input  grant, chosen, given, state_dbg, ptr_dbg
    );

    modport slave (
        input  request, pkt_release,
        output grant, chosen, given, state_dbg, ptr_dbg
    );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Finds the first set request bit at
// index pointer, pointer+1, ... wrapping modulo NUM_PORTS.
//   request : per-port request vector
//   pointer : highest-priority index (0..NUM_PORTS-1)
//   found   : 1 when any request bit is set
//   winner  : index of the selected port (valid when found = 1)
// Implemented as rotate, find-first, un-rotate; every index addition wraps
// with an explicit compare-and-subtract so NUM_PORTS need not be 2**k.
// -----------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : ARB_PTR_W_MIN
) (
    input  logic [NUM_PORTS-1:0] request,
    input  logic [PTR_W-1:0]     pointer,
    output logic                 found,
    output logic [PTR_W-1:0]     winner
);

    function automatic logic [PTR_W-1:0] mod_add(input int unsigned a, input int unsigned b);
        int unsigned s;
        s = a + b;
        if (s >= NUM_PORTS) begin
            s = s - NUM_PORTS;
        end
        return PTR_W'(s);
    endfunction

    logic [NUM_PORTS-1:0] rotated;
    logic [PTR_W-1:0]     offset;

    always_comb begin
        rotated = '0;
        found   = 1'b0;
        offset  = '0;
        // rotated[0] is the request at the pointer, i.e. highest priority
        for (int i = 0; i < NUM_PORTS; i++) begin
            rotated[i] = request[mod_add(unsigned'(i), 32'(pointer))];
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rotated[i] && !found) begin
                found  = 1'b1;
                offset = PTR_W'(i);
            end
        end
        winner = mod_add(32'(offset), 32'(pointer));
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter
// Round-robin arbiter with registered one-hot grant, internal rotating
// priority pointer and optional packet lock.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : rr_lock_arbiter_if.slave (request, pkt_release in;
//           grant, chosen, given, state_dbg, ptr_dbg out)
// Parameters:
//   NUM_PORTS : number of requesters (>= 2)
//   LOCK_MODE : 1 = hold grant until release/abort, 0 = re-pick every cycle
//   PTR_W     : derived index width, do not override
// -----------------------------------------------------------------------------
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int LOCK_MODE = 1,
    parameter int PTR_W     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : ARB_PTR_W_MIN
) (
    input  logic               clk,
    input  logic               reset,
    rr_lock_arbiter_if.slave   bus
);

    arb_state_t           state;
    logic [PTR_W-1:0]     pointer;
    logic [NUM_PORTS-1:0] grant_q;
    logic [PTR_W-1:0]     chosen_q;
    logic                 given_q;

    logic                 found;
    logic [PTR_W-1:0]     winner;
    logic [PTR_W-1:0]     next_ptr;
    logic                 hold;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .request (bus.request),
        .pointer (pointer),
        .found   (found),
        .winner  (winner)
    );

    assign next_ptr = PTR_W'(wrap_inc(32'(winner), NUM_PORTS));

    // The current owner keeps the grant while it still requests and has not
    // signalled end of packet. Strobes on other ports never reach here.
    assign hold = bus.request[chosen_q] && !bus.pkt_release[chosen_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pointer  <= '0;
            grant_q  <= '0;
            chosen_q <= '0;
            given_q  <= 1'b0;
        end else if ((state == LOCKED) && hold) begin
            state <= LOCKED;
        end else if (found) begin
            // Covers both a fresh pick from IDLE and a same-cycle handover
            // out of LOCKED; the pointer already sits past the old owner, so
            // it competes only as lowest priority.
            grant_q  <= NUM_PORTS'(1) << winner;
            chosen_q <= winner;
            given_q  <= 1'b1;
            pointer  <= next_ptr;
            state    <= (LOCK_MODE != 0) ? LOCKED : IDLE;
        end else begin
            // chosen_q intentionally keeps the last winner
            grant_q <= '0;
            given_q <= 1'b0;
            state   <= IDLE;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.chosen    = chosen_q;
    assign bus.given     = given_q;
    assign bus.state_dbg = state;
    assign bus.ptr_dbg   = pointer;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_lock_arbiter
// Drives three arbiters from one directed sequence:
//   dut_a : NUM_PORTS = 4, LOCK_MODE = 1
//   dut_b : NUM_PORTS = 4, LOCK_MODE = 0
//   dut_c : NUM_PORTS = 3, LOCK_MODE = 1
// Expected {grant, chosen, given} words are queued when inputs are set up
// for a cycle and compared one step after the following rising edge.
// -----------------------------------------------------------------------------
module tb_rr_lock_arbiter;
    import arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_lock_arbiter_if #(.NUM_PORTS(4)) a_if ();
    rr_lock_arbiter_if #(.NUM_PORTS(4)) b_if ();
    rr_lock_arbiter_if #(.NUM_PORTS(3)) c_if ();

    rr_lock_arbiter #(.NUM_PORTS(4), .LOCK_MODE(1)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
    rr_lock_arbiter #(.NUM_PORTS(4), .LOCK_MODE(0)) dut_b (.clk(clk), .reset(reset), .bus(b_if));
    rr_lock_arbiter #(.NUM_PORTS(3), .LOCK_MODE(1)) dut_c (.clk(clk), .reset(reset), .bus(c_if));

    // ---------------- scoreboard ----------------
    // packed as {grant[3:0], chosen[1:0], given}; 3-port grant zero-extended
    logic [6:0] exp_a_q[$];
    logic [6:0] exp_b_q[$];
    logic [6:0] exp_c_q[$];
    string      tag_a_q[$];
    string      tag_b_q[$];
    string      tag_c_q[$];

    int compared   = 0;
    int mismatched = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_a(input string t, input logic [3:0] g, input logic [1:0] c, input logic gv);
        exp_a_q.push_back({g, c, gv});
        tag_a_q.push_back(t);
    endtask

    task automatic push_b(input string t, input logic [3:0] g, input logic [1:0] c, input logic gv);
        exp_b_q.push_back({g, c, gv});
        tag_b_q.push_back(t);
    endtask

    task automatic push_c(input string t, input logic [2:0] g, input logic [1:0] c, input logic gv);
        exp_c_q.push_back({1'b0, g, c, gv});
        tag_c_q.push_back(t);
    endtask

    // ---------------- driver: advance one cycle, then score ----------------
    task automatic tick();
        logic [6:0] e;
        string      t;
        @(posedge clk);
        #1;
        if (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            t = tag_a_q.pop_front();
            check_val(t, {1'b0, a_if.grant, a_if.chosen, a_if.given}, {1'b0, e});
        end
        if (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            t = tag_b_q.pop_front();
            check_val(t, {1'b0, b_if.grant, b_if.chosen, b_if.given}, {1'b0, e});
        end
        if (exp_c_q.size() > 0) begin
            e = exp_c_q.pop_front();
            t = tag_c_q.pop_front();
            check_val(t, {2'b0, c_if.grant, c_if.chosen, c_if.given}, {1'b0, e});
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int         mp;
        int         w;
        int         cur;
        int         nxt;
        int         last_ch;
        logic [3:0] rq;
        logic       fnd;

        reset            = 1'b1;
        a_if.request     = 4'b1111;
        a_if.pkt_release = 4'b0000;
        b_if.request     = 4'b1111;
        b_if.pkt_release = 4'b0000;
        c_if.request     = 3'b111;
        c_if.pkt_release = 3'b000;

        // Reset held two cycles with everyone requesting: outputs stay zero
        for (int k = 0; k < 2; k++) begin
            push_a("rst_a", 4'b0000, 2'd0, 1'b0);
            push_b("rst_b", 4'b0000, 2'd0, 1'b0);
            push_c("rst_c", 3'b000, 2'd0, 1'b0);
            tick();
        end
        check_val("rst_a_ptr", 8'(a_if.ptr_dbg), 8'd0);
        check_val("rst_a_state", 8'(a_if.state_dbg), 8'(IDLE));

        // Release reset: first grant is port 0; dut_b rotates every cycle
        reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            push_a("lock_hold_a", 4'b0001, 2'd0, 1'b1);
            push_b("fair_b", 4'(1 << (k % 4)), 2'(k % 4), 1'b1);
            push_c("lock_hold_c", 3'b001, 2'd0, 1'b1);
            tick();
        end
        check_val("a_locked_state", 8'(a_if.state_dbg), 8'(LOCKED));
        check_val("a_locked_ptr", 8'(a_if.ptr_dbg), 8'd1);

        // Lock and handover: 0101, port 0 held 5 cycles, then port 2
        reset        = 1'b1;
        a_if.request = 4'b0101;
        push_a("rst2_a", 4'b0000, 2'd0, 1'b0);
        tick();
        reset = 1'b0;
        push_a("hand_c1", 4'b0001, 2'd0, 1'b1);
        tick();
        a_if.pkt_release = 4'b0100;   // strobe from a non-owner
        push_a("hand_c2_ignore_rel2", 4'b0001, 2'd0, 1'b1);
        tick();
        a_if.pkt_release = 4'b0000;
        push_a("hand_c3", 4'b0001, 2'd0, 1'b1);
        tick();
        push_a("hand_c4", 4'b0001, 2'd0, 1'b1);
        tick();
        push_a("hand_c5", 4'b0001, 2'd0, 1'b1);
        tick();
        a_if.pkt_release = 4'b0001;   // end of packet in the 5th cycle
        push_a("hand_next_p2", 4'b0100, 2'd2, 1'b1);
        tick();
        a_if.pkt_release = 4'b0000;
        check_val("hand_ptr", 8'(a_if.ptr_dbg), 8'd3);
        check_val("hand_state", 8'(a_if.state_dbg), 8'(LOCKED));

        // Abort: port 2 drops, port 1 wins; port 1 drops, port 3 wins
        a_if.request = 4'b0010;
        push_a("abort_to_p1", 4'b0010, 2'd1, 1'b1);
        tick();
        a_if.request = 4'b1000;
        push_a("abort_to_p3", 4'b1000, 2'd3, 1'b1);
        tick();
        a_if.request = 4'b0000;
        push_a("abort_to_idle", 4'b0000, 2'd3, 1'b0);
        tick();
        check_val("abort_idle_state", 8'(a_if.state_dbg), 8'(IDLE));
        a_if.pkt_release = 4'b1111;   // strobes in IDLE do nothing
        push_a("idle_rel_ignored", 4'b0000, 2'd3, 1'b0);
        tick();
        a_if.pkt_release = 4'b0000;

        // Reset mid-lock: port 2 locked, reset drops it, then 1100 -> port 2
        a_if.request = 4'b0100;
        c_if.request = 3'b000;
        push_a("midlock_p2", 4'b0100, 2'd2, 1'b1);
        tick();
        reset = 1'b1;
        push_a("midlock_rst", 4'b0000, 2'd0, 1'b0);
        tick();
        check_val("midlock_rst_ptr", 8'(a_if.ptr_dbg), 8'd0);
        check_val("midlock_rst_state", 8'(a_if.state_dbg), 8'(IDLE));
        reset        = 1'b0;
        a_if.request = 4'b1100;
        push_a("after_rst_p2", 4'b0100, 2'd2, 1'b1);
        tick();

        // Three-port wrap: pointer to 2, then 011 with release -> port 0
        c_if.request = 3'b010;
        push_c("c_p1", 3'b010, 2'd1, 1'b1);
        tick();
        check_val("c_ptr_2", 8'(c_if.ptr_dbg), 8'd2);
        c_if.request     = 3'b011;
        c_if.pkt_release = 3'b010;
        push_c("c_wrap_p0", 3'b001, 2'd0, 1'b1);
        tick();
        check_val("c_ptr_1", 8'(c_if.ptr_dbg), 8'd1);
        c_if.request = 3'b111;
        cur          = 0;
        for (int k = 0; k < 6; k++) begin
            c_if.pkt_release = 3'(1 << cur);
            nxt = (cur + 1) % 3;
            push_c("c_rotate", 3'(1 << nxt), 2'(nxt), 1'b1);
            tick();
            check_val("c_chosen_lt3", 8'(c_if.chosen < 2'd3), 8'd1);
            cur = nxt;
        end
        c_if.pkt_release = 3'b000;

        // Random requests on the non-locking arbiter against a reference
        reset = 1'b1;
        push_b("rst3_b", 4'b0000, 2'd0, 1'b0);
        tick();
        reset   = 1'b0;
        mp      = 0;
        last_ch = 0;
        for (int k = 0; k < 24; k++) begin
            rq           = 4'($urandom_range(0, 15));
            b_if.request = rq;
            fnd          = 1'b0;
            w            = 0;
            for (int off = 0; off < 4; off++) begin
                if (!fnd && rq[(mp + off) % 4]) begin
                    fnd = 1'b1;
                    w   = (mp + off) % 4;
                end
            end
            if (fnd) begin
                push_b("rand_b", 4'(1 << w), 2'(w), 1'b1);
                mp      = (w + 1) % 4;
                last_ch = w;
            end else begin
                push_b("rand_b_none", 4'b0000, 2'(last_ch), 1'b0);
            end
            tick();
        end

        check_val("queues_drained", 8'(exp_a_q.size() + exp_b_q.size() + exp_c_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
